// File: rtl/finder_scan_scheduler.sv
// Runs the horizontal then vertical finder-pattern scanners over one frame, sharing the single
// frame-buffer read port, capturing both encoding vectors and guarding each pass with a watchdog.
module finder_scan_scheduler #(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int ENC_W          = 480,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             frame_ready,
    input  logic             h_en,
    input  logic             v_en,
    output logic [19:0]      bram_addr,
    input  logic             bram_pixel,
    output logic             h_rst,
    output logic             v_rst,
    output logic             h_start,
    output logic             v_start,
    output logic             h_pixel,
    output logic             v_pixel,
    input  logic [19:0]      h_pixel_address,
    input  logic [19:0]      v_pixel_address,
    input  logic [ENC_W-1:0] h_encodings,
    input  logic [ENC_W-1:0] v_encodings,
    input  logic             h_data_valid,
    input  logic             v_data_valid,
    output logic [ENC_W-1:0] row_enc,
    output logic [ENC_W-1:0] col_enc,
    output logic             results_valid,
    output logic             busy,
    output logic             timeout_err,
    output logic [3:0]       state_dbg
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_H_RESET = 4'd1;
    localparam logic [3:0] S_H_START = 4'd2;
    localparam logic [3:0] S_H_RUN   = 4'd3;
    localparam logic [3:0] S_V_RESET = 4'd4;
    localparam logic [3:0] S_V_START = 4'd5;
    localparam logic [3:0] S_V_RUN   = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERROR   = 4'd8;

    localparam logic [20:0] TIMER_LAST = 21'(TIMEOUT_CYCLES - 1);

    // The frame must be addressable on 20 bits and the watchdog limit must fit the 21-bit timer.
    if ((WIDTH * HEIGHT > (1 << 20)) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > (1 << 21))) begin : g_bad_params
        $error("finder_scan_scheduler: frame size or timeout out of range");
    end

    logic [3:0]       state_q, state_d;
    logic [20:0]      timer_q, timer_d;
    logic             pending_q, pending_d;
    logic [ENC_W-1:0] row_q, row_d;
    logic [ENC_W-1:0] col_q, col_d;
    logic             terr_q, terr_d;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        row_d     = row_q;
        col_d     = col_q;
        terr_d    = terr_q;

        if (frame_ready && (state_q != S_IDLE)) pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (frame_ready) begin
                    if (h_en)      state_d = S_H_RESET;
                    else if (v_en) state_d = S_V_RESET;
                end
            end
            S_H_RESET: state_d = S_H_START;
            S_H_START: begin
                timer_d = '0;
                state_d = S_H_RUN;
            end
            S_H_RUN: begin
                timer_d = timer_q + 21'd1;
                // A completion on the final watchdog cycle still counts as a good pass.
                if (h_data_valid) begin
                    row_d   = h_encodings;
                    state_d = v_en ? S_V_RESET : S_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_V_RESET: state_d = S_V_START;
            S_V_START: begin
                timer_d = '0;
                state_d = S_V_RUN;
            end
            S_V_RUN: begin
                timer_d = timer_q + 21'd1;
                if (v_data_valid) begin
                    col_d   = v_encodings;
                    state_d = S_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE: begin
                // A frame that arrived while busy restarts the sequence without passing through IDLE.
                pending_d = 1'b0;
                state_d   = S_IDLE;
                if (pending_q || frame_ready) begin
                    if (h_en)      state_d = S_H_RESET;
                    else if (v_en) state_d = S_V_RESET;
                end
            end
            S_ERROR: begin
                pending_d = 1'b0;
                terr_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (((state_q == S_IDLE) || (state_q == S_DONE)) &&
            ((state_d == S_H_RESET) || (state_d == S_V_RESET))) begin
            terr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            pending_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            row_q     <= row_d;
            col_q     <= col_d;
            terr_q    <= terr_d;
        end
    end

    // Address select comes from registered state so it never glitches inside a scanner's read window.
    always_comb begin
        bram_addr = '0;
        if (state_q == S_H_RUN)      bram_addr = h_pixel_address;
        else if (state_q == S_V_RUN) bram_addr = v_pixel_address;
    end

    assign h_rst         = !rst_in || (state_q == S_H_RESET);
    assign v_rst         = !rst_in || (state_q == S_V_RESET);
    assign h_start       = (state_q == S_H_START);
    assign v_start       = (state_q == S_V_START);
    assign h_pixel       = bram_pixel;
    assign v_pixel       = bram_pixel;
    assign row_enc       = row_q;
    assign col_enc       = col_q;
    assign results_valid = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);
    assign timeout_err   = terr_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_finder_scan_scheduler.sv
// Bench for finder_scan_scheduler: latency-programmable scanner models, per-frame outcome
// prediction from pass latencies and the watchdog limit, and a queue of expected result pairs.
`timescale 1ns/1ps
module tb_finder_scan_scheduler;

    localparam int ENC_W = 480;
    localparam int TO    = 50;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             frame_ready = 1'b0;
    logic             h_en = 1'b0;
    logic             v_en = 1'b0;
    logic [19:0]      bram_addr;
    logic             bram_pixel = 1'b0;
    logic             h_rst, v_rst, h_start, v_start, h_pixel, v_pixel;
    logic [19:0]      h_pixel_address = '0;
    logic [19:0]      v_pixel_address = '0;
    logic [ENC_W-1:0] h_encodings = '0;
    logic [ENC_W-1:0] v_encodings = '0;
    logic             h_data_valid = 1'b0;
    logic             v_data_valid = 1'b0;
    logic [ENC_W-1:0] row_enc, col_enc;
    logic             results_valid, busy, timeout_err;
    logic [3:0]       state_dbg;

    finder_scan_scheduler #(
        .WIDTH(640), .HEIGHT(480), .ENC_W(ENC_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .frame_ready(frame_ready), .h_en(h_en), .v_en(v_en),
        .bram_addr(bram_addr), .bram_pixel(bram_pixel),
        .h_rst(h_rst), .v_rst(v_rst), .h_start(h_start), .v_start(v_start),
        .h_pixel(h_pixel), .v_pixel(v_pixel),
        .h_pixel_address(h_pixel_address), .v_pixel_address(v_pixel_address),
        .h_encodings(h_encodings), .v_encodings(v_encodings),
        .h_data_valid(h_data_valid), .v_data_valid(v_data_valid),
        .row_enc(row_enc), .col_enc(col_enc), .results_valid(results_valid),
        .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    // scoreboard state
    int checks = 0;
    int errors = 0;
    logic [2*ENC_W-1:0] exp_q[$];
    logic [ENC_W-1:0]   exp_row = '0;
    logic [ENC_W-1:0]   exp_col = '0;
    logic               exp_terr = 1'b0;

    // monitor counters
    int cyc = 0;
    int fr_cyc = -10;
    int h_rst_n, v_rst_n, h_start_n, v_start_n, busy_n, busy_rise, addr_bad, pix_bad;
    int h_rst_first, v_rst_first, h_start_first, v_start_first;
    logic terr_at2;
    logic busy_prev = 1'b0;

    // scanner models: *_idx is the RUN cycle number the scheduler should be in, 0 when idle
    int h_idx = 0, v_idx = 0, h_lat = 0, v_lat = 0;
    logic [19:0]        exp_addr;
    logic [2*ENC_W-1:0] rv_exp;

    task automatic check(input string tag, input logic [2*ENC_W-1:0] got, input logic [2*ENC_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (low 128 bits)", tag, got[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [ENC_W-1:0] rand_vec();
        logic [ENC_W-1:0] v;
        for (int i = 0; i < ENC_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic clear_counters();
        h_rst_n = 0; v_rst_n = 0; h_start_n = 0; v_start_n = 0;
        busy_n = 0; busy_rise = 0; addr_bad = 0; pix_bad = 0;
        h_rst_first = -1; v_rst_first = -1; h_start_first = -1; v_start_first = -1;
        terr_at2 = 1'bx;
    endtask

    always @(negedge clk_in) begin
        cyc++;
        h_data_valid = 1'b0;
        v_data_valid = 1'b0;
        exp_addr = '0;
        if (h_idx > 0) exp_addr = h_pixel_address;
        if (v_idx > 0) exp_addr = v_pixel_address;
        if (rst_in) begin
            if (bram_addr !== exp_addr) addr_bad++;
            if (h_pixel !== bram_pixel || v_pixel !== bram_pixel) pix_bad++;
            if (h_rst)   begin h_rst_n++;   if (h_rst_first < 0)   h_rst_first = cyc;   end
            if (v_rst)   begin v_rst_n++;   if (v_rst_first < 0)   v_rst_first = cyc;   end
            if (h_start) begin h_start_n++; if (h_start_first < 0) h_start_first = cyc; end
            if (v_start) begin v_start_n++; if (v_start_first < 0) v_start_first = cyc; end
            if (busy) busy_n++;
            if (busy && !busy_prev) busy_rise++;
            if (cyc == fr_cyc + 2) terr_at2 = timeout_err;
            if (results_valid) begin
                if (exp_q.size() == 0) check("rv_unexpected", 1, 0);
                else begin
                    rv_exp = exp_q.pop_front();
                    check("rv_data", {row_enc, col_enc}, rv_exp);
                end
            end
        end
        busy_prev = busy;
        if (h_idx > 0) begin
            if (h_idx == h_lat) begin h_data_valid = 1'b1; h_idx = 0; end
            else if (h_idx == TO) h_idx = 0;
            else h_idx++;
        end
        if (v_idx > 0) begin
            if (v_idx == v_lat) begin v_data_valid = 1'b1; v_idx = 0; end
            else if (v_idx == TO) v_idx = 0;
            else v_idx++;
        end
        if (h_start) h_idx = 1;
        if (v_start) v_idx = 1;
        if (h_rst) h_idx = 0;
        if (v_rst) v_idx = 0;
        bram_pixel = 1'($urandom_range(0, 1));
    end

    // driver: one frame_ready (plus two more while busy if extra), then predict and check the outcome
    task automatic run_frame(input bit hen, input bit ven, input int hlat, input int vlat,
                             input logic [ENC_W-1:0] hvec, input logic [ENC_W-1:0] vvec,
                             input logic [19:0] haddr, input logic [19:0] vaddr, input bit extra);
        bit any, h_ok, v_ok, ok;
        int bc, scans, wait_n;
        logic terr_before;
        @(negedge clk_in); #1;
        h_en = hen; v_en = ven; h_lat = hlat; v_lat = vlat;
        h_encodings = hvec; v_encodings = vvec;
        h_pixel_address = haddr; v_pixel_address = vaddr;

        any  = hen || ven;
        h_ok = !hen || (hlat <= TO);
        v_ok = !ven || (vlat <= TO);
        ok   = h_ok && v_ok;
        bc   = 1;
        if (hen) bc += 2 + ((hlat <= TO) ? hlat : TO);
        if (h_ok && ven) bc += 2 + ((vlat <= TO) ? vlat : TO);
        scans = !any ? 0 : ((extra && ok) ? 2 : 1);
        terr_before = exp_terr;
        if (any) begin
            if (hen && h_ok) exp_row = hvec;
            if (ven && h_ok && v_ok) exp_col = vvec;
            exp_terr = !ok;
            if (ok) repeat (scans) exp_q.push_back({exp_row, exp_col});
        end

        clear_counters();
        @(negedge clk_in); #1;
        fr_cyc = cyc;
        frame_ready = 1'b1;
        @(negedge clk_in); #1 frame_ready = 1'b0;
        if (extra) begin
            @(negedge clk_in); @(negedge clk_in); #1 frame_ready = 1'b1;
            @(negedge clk_in); #1 frame_ready = 1'b0;
            @(negedge clk_in); #1 frame_ready = 1'b1;
            @(negedge clk_in); #1 frame_ready = 1'b0;
        end
        repeat (2) @(negedge clk_in);
        wait_n = 0;
        while (busy === 1'b1 && wait_n < 2000) begin
            @(negedge clk_in);
            wait_n++;
        end
        check("done_wait", wait_n < 2000, 1);
        repeat (3) @(negedge clk_in);
        #1;

        check("busy_cycles", busy_n, bc * scans);
        check("busy_rise", busy_rise, any ? 1 : 0);
        check("h_rst_n", h_rst_n, hen * scans);
        check("h_start_n", h_start_n, hen * scans);
        check("v_rst_n", v_rst_n, (ven && h_ok) * scans);
        check("v_start_n", v_start_n, (ven && h_ok) * scans);
        if (hen) begin
            check("h_rst_lat", h_rst_first, fr_cyc + 1);
            check("h_start_lat", h_start_first, fr_cyc + 2);
        end else if (ven) begin
            check("v_rst_lat", v_rst_first, fr_cyc + 1);
            check("v_start_lat", v_start_first, fr_cyc + 2);
        end
        check("terr_at_start", terr_at2, any ? 1'b0 : terr_before);
        check("row_enc", row_enc, exp_row);
        check("col_enc", col_enc, exp_col);
        check("timeout_err", timeout_err, exp_terr);
        check("rv_left", exp_q.size(), 0);
        check("addr_follow", addr_bad, 0);
        check("pixel_pass", pix_bad, 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {busy, h_rst, v_rst, h_start, v_start, results_valid, timeout_err}, 7'b0110000);
        check({tag, "_addr"}, bram_addr, 0);
        check({tag, "_enc"}, {row_enc, col_enc}, 0);
    endtask

    initial begin
        bit hen, ven, ext;
        int hl, vl;
        clear_counters();
        repeat (2) @(negedge clk_in);
        #1 check_reset_outputs("por");
        rst_in = 1'b1;

        run_frame(1, 0, 40, 0, ENC_W'(5), ENC_W'(0), 20'h12345, 20'h0, 0);
        run_frame(1, 1, 30, 25, ENC_W'('hA), ENC_W'(3), 20'h12345, 20'h00ABC, 0);
        run_frame(1, 1, 20, 1000, rand_vec(), rand_vec(), 20'h0F0F0, 20'h00ABC, 0);
        run_frame(1, 0, TO, 0, rand_vec(), rand_vec(), 20'h00001, 20'h0, 0);
        run_frame(0, 1, 0, TO + 1, rand_vec(), rand_vec(), 20'h0, 20'h4B000, 0);
        run_frame(1, 1, 30, 20, rand_vec(), rand_vec(), 20'h01234, 20'h04321, 1);
        run_frame(0, 0, 10, 10, rand_vec(), rand_vec(), 20'h11111, 20'h22222, 0);

        // reset in the middle of a horizontal pass
        @(negedge clk_in); #1;
        h_en = 1'b1; v_en = 1'b1; h_lat = 40; v_lat = 20;
        frame_ready = 1'b1;
        @(negedge clk_in); #1 frame_ready = 1'b0;
        repeat (8) @(negedge clk_in);
        #1 rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in); #1;
            check_reset_outputs("mid_rst");
        end
        rst_in = 1'b1;
        exp_row = '0; exp_col = '0; exp_terr = 1'b0;
        clear_counters();
        repeat (5) @(negedge clk_in);
        #1 check("idle_after_rst", busy_n, 0);
        run_frame(1, 1, 15, 15, rand_vec(), rand_vec(), 20'h00100, 20'h00200, 0);

        for (int n = 0; n < 16; n++) begin
            hen = 1'($urandom_range(0, 1));
            ven = 1'($urandom_range(0, 1));
            hl  = $urandom_range(10, TO + 10);
            vl  = $urandom_range(10, TO + 10);
            ext = ($urandom_range(0, 3) == 0);
            run_frame(hen, ven, hl, vl, rand_vec(), rand_vec(),
                      20'($urandom_range(0, 307199)), 20'($urandom_range(0, 307199)), ext);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
